// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done handshake and result bundle for bin2bcd_seq
interface bin2bcd_seq_if #(
    parameter int BIN_W = 27
);
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic [31:0]      digits;
    logic             ovf;

    modport master (
        output start, bin,
        input  busy, done, digits, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, digits, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to 8-digit packed BCD converter
// Optional BCD_BLANK_LEADING_ZEROS_EN: leading zero digits committed as 4'hF (blank).
module bin2bcd_seq #(
    parameter int BIN_W = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);

`ifdef BCD_BLANK_LEADING_ZEROS_EN
    localparam logic [31:0] DIGITS_RST = 32'hFFFF_FFF0;
`else
    localparam logic [31:0] DIGITS_RST = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [31:0]      digits_q, digits_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [31:0]      adj;
    logic [31:0]      result;
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    logic             leading;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= DIGITS_RST;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Nibbles never exceed 9 here, so the +3 stays inside each nibble.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 8; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        result = scratch_q;
`ifdef BCD_BLANK_LEADING_ZEROS_EN
        leading = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (leading && (scratch_q[4*i +: 4] == 4'd0)) begin
                result[4*i +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CONV;
                    bin_d      = bus.bin;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = ({{(32-BIN_W){1'b0}}, bus.bin} > 32'd99_999_999);
                end
            end
            CONV: begin
                scratch_d = {adj[30:0], bin_q[BIN_W-1]};
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                digits_d = ovf_pend_q ? 32'h9999_9999 : result;
                ovf_d    = ovf_pend_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.digits = digits_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq (BIN_W 27 and 4)
module tb_bin2bcd_seq;
    logic clk;
    logic rst_n;

    bin2bcd_seq_if #(.BIN_W(27)) bus ();
    bin2bcd_seq_if #(.BIN_W(4))  bus4 ();

    bin2bcd_seq #(.BIN_W(27)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    bin2bcd_seq #(.BIN_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

`ifdef BCD_BLANK_LEADING_ZEROS_EN
    localparam logic [31:0] E_RST   = 32'hFFFF_FFF0;
    localparam logic [31:0] E_406   = 32'hFFFF_F406;
    localparam logic [31:0] E_8     = 32'hFFFF_FFF8;
    localparam logic [31:0] E_15    = 32'hFFFF_FF15;
`else
    localparam logic [31:0] E_RST   = 32'h0000_0000;
    localparam logic [31:0] E_406   = 32'h0000_0406;
    localparam logic [31:0] E_8     = 32'h0000_0008;
    localparam logic [31:0] E_15    = 32'h0000_0015;
`endif

    int errors = 0;
    int checks = 0;
    int cyc;
    int busy_cnt;
    int pulses;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the accepting edge until done is seen, plus busy samples on the way.
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = bus.busy ? 1 : 0;
        while (!bus.done && n < 200) begin
            tick();
            n++;
            if (bus.busy) nbusy++;
        end
    endtask

    task automatic accept(input logic [26:0] value);
        bus.start = 1'b1;
        bus.bin   = value;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin    = '0;
        bus4.start = 1'b0;
        bus4.bin   = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_digits", bus.digits, E_RST);
        rst_n = 1'b1;

        // zero
        accept(27'd0);
        chk("zero_busy_after_accept", {31'd0, bus.busy}, 32'd1);
        wait_done(cyc, busy_cnt);
        chk("zero_latency", cyc, 32'd28);
        chk("zero_digits", bus.digits, E_RST);
        chk("zero_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("zero_busy_at_done", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("zero_done_one_cycle", {31'd0, bus.done}, 32'd0);

        // 12_345_678 with busy width
        accept(27'd12_345_678);
        wait_done(cyc, busy_cnt);
        chk("mid_latency", cyc, 32'd28);
        chk("mid_busy_cycles", busy_cnt, 32'd28);
        chk("mid_digits", bus.digits, 32'h1234_5678);
        chk("mid_ovf", {31'd0, bus.ovf}, 32'd0);
        tick();
        chk("mid_done_low", {31'd0, bus.done}, 32'd0);
        chk("mid_digits_held", bus.digits, 32'h1234_5678);

        // start ignored while busy, bin changes ignored
        accept(27'd406);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.bin   = 27'd777;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign_digits_stable", bus.digits, 32'h1234_5678);
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("ign_done_seen", {31'd0, bus.done}, 32'd1);
        chk("ign_digits", bus.digits, E_406);
        pulses = 0;
        repeat (40) begin
            tick();
            if (bus.done) pulses++;
        end
        chk("ign_single_done", pulses, 32'd0);
        chk("ign_idle", {31'd0, bus.busy}, 32'd0);

        // back-to-back with start in the done cycle
        accept(27'd99_999_999);
        wait_done(cyc, busy_cnt);
        chk("b2b_first_digits", bus.digits, 32'h9999_9999);
        chk("b2b_first_ovf", {31'd0, bus.ovf}, 32'd0);
        accept(27'd100_000_000);
        chk("b2b_accepted", {31'd0, bus.busy}, 32'd1);
        wait_done(cyc, busy_cnt);
        chk("b2b_spacing", cyc + 1, 32'd29);
        chk("b2b_second_digits", bus.digits, 32'h9999_9999);
        chk("b2b_second_ovf", {31'd0, bus.ovf}, 32'd1);

        // async reset mid-conversion
        tick();
        accept(27'd55);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_digits", bus.digits, E_RST);
        chk("abort_ovf", {31'd0, bus.ovf}, 32'd0);
        pulses = 0;
        repeat (35) begin
            tick();
            if (bus.done) pulses++;
        end
        chk("abort_no_done", pulses, 32'd0);
        rst_n = 1'b1;
        accept(27'd8);
        chk("post_rst_accept", {31'd0, bus.busy}, 32'd1);
        wait_done(cyc, busy_cnt);
        chk("post_rst_latency", cyc, 32'd28);
        chk("post_rst_digits", bus.digits, E_8);

        // narrow instance
        bus4.start = 1'b1;
        bus4.bin   = 4'd15;
        tick();
        bus4.start = 1'b0;
        cyc = 0;
        while (!bus4.done && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("w4_latency", cyc, 32'd5);
        chk("w4_digits", bus4.digits, E_15);
        chk("w4_ovf", {31'd0, bus4.ovf}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
